// File: rtl/vignette_ctrl.sv
// Vignette filter sequencer: tracks stream pixel coordinates, applies shadowed
// configuration at start of frame, holds gain-table writes until blanking and flags framing errors.
module vignette_ctrl #(
  parameter int H_ACTIVE = 1920,
  parameter int V_ACTIVE = 1080,
  parameter int LUT_BITS = 10,
  parameter int MUL_BITS = 8
) (
  input  logic                clk,
  input  logic                aresetn,
  input  logic                s_tvalid,
  input  logic                s_tready,
  input  logic                s_tuser,
  input  logic                s_tlast,
  output logic [10:0]         pix_x,
  output logic [10:0]         pix_y,
  input  logic                cfg_we,
  input  logic [2:0]          cfg_addr,
  input  logic [15:0]         cfg_wdata,
  output logic                cfg_ready,
  output logic [10:0]         center_x,
  output logic [10:0]         center_y,
  output logic                vig_enable,
  output logic                lut_we,
  output logic [LUT_BITS-1:0] lut_addr,
  output logic [MUL_BITS-1:0] lut_data,
  output logic [15:0]         frame_cnt,
  output logic [2:0]          err_flags
);

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    ACTIVE   = 2'd1,
    BLANK    = 2'd2
  } state_e;

  localparam logic [2:0]  ADDR_CX    = 3'd0;
  localparam logic [2:0]  ADDR_CY    = 3'd1;
  localparam logic [2:0]  ADDR_EN    = 3'd2;
  localparam logic [2:0]  ADDR_PTR   = 3'd3;
  localparam logic [2:0]  ADDR_LUT   = 3'd4;
  localparam logic [2:0]  ADDR_ERRC  = 3'd5;
  localparam logic [10:0] X_LAST     = 11'(H_ACTIVE - 1);
  localparam logic [10:0] Y_LAST     = 11'(V_ACTIVE - 1);
  localparam logic [10:0] COORD_MAX  = 11'h7FF;

  state_e                state_q, state_d;
  logic [10:0]           xCnt_q, xCnt_d, yCnt_q, yCnt_d;
  logic [10:0]           shadowCx_q, shadowCx_d, shadowCy_q, shadowCy_d;
  logic                  shadowEn_q, shadowEn_d;
  logic [10:0]           centerX_q, centerY_q;
  logic                  enable_q;
  logic [LUT_BITS-1:0]   lutPtr_q, lutPtr_d;
  logic                  lutWe_q;
  logic [LUT_BITS-1:0]   lutAddr_q;
  logic [MUL_BITS-1:0]   lutData_q;
  logic [15:0]           frameCnt_q;
  logic [2:0]            err_q, err_d;

  logic                  beat, sof, cfgAccept, lutWrite, advance;
  logic [10:0]           curX, curY;
  logic [2:0]            errEvent, errClear;
  logic                  unusedBits;

  assign beat      = s_tvalid & s_tready;
  assign sof       = beat & s_tuser;
  assign curX      = s_tuser ? 11'd0 : xCnt_q;
  assign curY      = s_tuser ? 11'd0 : yCnt_q;
  assign cfg_ready = !((cfg_addr == ADDR_LUT) && (state_q == ACTIVE));
  assign cfgAccept = cfg_we & cfg_ready;
  assign lutWrite  = cfgAccept && (cfg_addr == ADDR_LUT);
  assign unusedBits = ^cfg_wdata;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state_q <= WAIT_SOF;
    else          state_q <= state_d;
  end

  // Frame sequencing; outside ACTIVE only a start-of-frame beat moves the counters.
  always_comb begin
    state_d  = state_q;
    xCnt_d   = xCnt_q;
    yCnt_d   = yCnt_q;
    errEvent = 3'b000;
    advance  = 1'b0;
    case (state_q)
      WAIT_SOF, BLANK: begin
        if (sof) begin
          state_d = ACTIVE;
          advance = 1'b1;
        end
      end
      ACTIVE: begin
        if (beat) begin
          advance = 1'b1;
          if (s_tuser && ((xCnt_q != 11'd0) || (yCnt_q != 11'd0))) errEvent[2] = 1'b1;
          if (s_tlast && (curX < X_LAST))                          errEvent[0] = 1'b1;
          if (!s_tlast && (curX == X_LAST))                        errEvent[1] = 1'b1;
          if (s_tlast && (curY == Y_LAST))                         state_d = BLANK;
        end
      end
      default: state_d = WAIT_SOF;
    endcase
    if (advance) begin
      if (s_tlast) begin
        xCnt_d = 11'd0;
        yCnt_d = (curY == COORD_MAX) ? COORD_MAX : curY + 11'd1;
      end else begin
        xCnt_d = (curX == COORD_MAX) ? COORD_MAX : curX + 11'd1;
      end
    end
  end

  // A shadow write coinciding with the SOF beat is folded into that apply.
  always_comb begin
    shadowCx_d = shadowCx_q;
    shadowCy_d = shadowCy_q;
    shadowEn_d = shadowEn_q;
    lutPtr_d   = lutPtr_q;
    errClear   = 3'b000;
    if (cfgAccept) begin
      case (cfg_addr)
        ADDR_CX:   shadowCx_d = cfg_wdata[10:0];
        ADDR_CY:   shadowCy_d = cfg_wdata[10:0];
        ADDR_EN:   shadowEn_d = cfg_wdata[0];
        ADDR_PTR:  lutPtr_d   = cfg_wdata[LUT_BITS-1:0];
        ADDR_LUT:  lutPtr_d   = lutPtr_q + 1'b1;
        ADDR_ERRC: errClear   = cfg_wdata[2:0];
        default:   ;
      endcase
    end
    err_d = (err_q & ~errClear) | errEvent;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      xCnt_q     <= '0;
      yCnt_q     <= '0;
      shadowCx_q <= 11'd960;
      shadowCy_q <= 11'd540;
      shadowEn_q <= 1'b0;
      centerX_q  <= 11'd960;
      centerY_q  <= 11'd540;
      enable_q   <= 1'b0;
      lutPtr_q   <= '0;
      lutWe_q    <= 1'b0;
      lutAddr_q  <= '0;
      lutData_q  <= '0;
      frameCnt_q <= '0;
      err_q      <= '0;
    end else begin
      xCnt_q     <= xCnt_d;
      yCnt_q     <= yCnt_d;
      shadowCx_q <= shadowCx_d;
      shadowCy_q <= shadowCy_d;
      shadowEn_q <= shadowEn_d;
      lutPtr_q   <= lutPtr_d;
      err_q      <= err_d;
      lutWe_q    <= lutWrite;
      if (lutWrite) begin
        lutAddr_q <= lutPtr_q;
        lutData_q <= cfg_wdata[MUL_BITS-1:0];
      end
      if (sof) begin
        centerX_q  <= shadowCx_d;
        centerY_q  <= shadowCy_d;
        enable_q   <= shadowEn_d;
        frameCnt_q <= frameCnt_q + 16'd1;
      end
    end
  end

  assign pix_x      = curX;
  assign pix_y      = curY;
  assign center_x   = centerX_q;
  assign center_y   = centerY_q;
  assign vig_enable = enable_q;
  assign lut_we     = lutWe_q;
  assign lut_addr   = lutAddr_q;
  assign lut_data   = lutData_q;
  assign frame_cnt  = frameCnt_q;
  assign err_flags  = err_q;

endmodule

// File: tb/tb_vignette_ctrl.sv
// Scoreboard bench for vignette_ctrl on a 4x3 frame: coordinates, shadow apply,
// gated gain-table writes, framing errors and mid-frame reset.
module tb_vignette_ctrl;

  localparam int H  = 4;
  localparam int V  = 3;
  localparam int LB = 10;
  localparam int MB = 8;

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic          s_tvalid = 1'b0, s_tready = 1'b0, s_tuser = 1'b0, s_tlast = 1'b0;
  logic [10:0]   pix_x, pix_y;
  logic          cfg_we = 1'b0;
  logic [2:0]    cfg_addr = 3'd0;
  logic [15:0]   cfg_wdata = 16'd0;
  logic          cfg_ready;
  logic [10:0]   center_x, center_y;
  logic          vig_enable;
  logic          lut_we;
  logic [LB-1:0] lut_addr;
  logic [MB-1:0] lut_data;
  logic [15:0]   frame_cnt;
  logic [2:0]    err_flags;

  vignette_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .LUT_BITS(LB), .MUL_BITS(MB)) dut (
    .clk(clk), .aresetn(aresetn),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tuser(s_tuser), .s_tlast(s_tlast),
    .pix_x(pix_x), .pix_y(pix_y),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_ready(cfg_ready),
    .center_x(center_x), .center_y(center_y), .vig_enable(vig_enable),
    .lut_we(lut_we), .lut_addr(lut_addr), .lut_data(lut_data),
    .frame_cnt(frame_cnt), .err_flags(err_flags)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;
  int expPix[$];
  int expLut[$];

  int mX, mY, mState, mFrames, mPtr;
  int mShCx, mShCy, mShEn, mCx, mCy, mEn;
  logic [2:0] mErr;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    mX = 0; mY = 0; mState = 0; mFrames = 0; mPtr = 0;
    mShCx = 960; mShCy = 540; mShEn = 0;
    mCx = 960; mCy = 540; mEn = 0;
    mErr = 3'b000;
  endtask

  task automatic modelSof();
    mCx = mShCx; mCy = mShCy; mEn = mShEn;
    mFrames = (mFrames + 1) % 65536;
  endtask

  task automatic checkState(input string tag);
    checkOutput({tag, ".center_x"},  center_x,   mCx);
    checkOutput({tag, ".center_y"},  center_y,   mCy);
    checkOutput({tag, ".vig_enable"}, vig_enable, mEn);
    checkOutput({tag, ".frame_cnt"}, frame_cnt,  mFrames);
    checkOutput({tag, ".err_flags"}, err_flags,  mErr);
  endtask

  // Drives one accepted beat, records its expected coordinate, then advances the model.
  task automatic applyStimulus(input logic user, input logic last);
    int cx, cy;
    bit adv;
    cx = user ? 0 : mX;
    cy = user ? 0 : mY;
    s_tvalid = 1'b1; s_tready = 1'b1; s_tuser = user; s_tlast = last;
    expPix.push_back(cx * 4096 + cy);
    @(posedge clk); #1;
    s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
    adv = 1'b0;
    if (mState == 1) begin
      adv = 1'b1;
      if (user) modelSof();
      if (user && (mX != 0 || mY != 0)) mErr[2] = 1'b1;
      if (last && cx < H - 1)           mErr[0] = 1'b1;
      if (!last && cx == H - 1)         mErr[1] = 1'b1;
      if (last && cy == V - 1)          mState = 2;
    end else if (user) begin
      modelSof();
      mState = 1;
      adv = 1'b1;
    end
    if (adv) begin
      if (last) begin
        mX = 0;
        mY = (cy + 1 > 2047) ? 2047 : cy + 1;
      end else begin
        mX = (cx + 1 > 2047) ? 2047 : cx + 1;
      end
    end
  endtask

  task automatic cfgWrite(input logic [2:0] a, input logic [15:0] d, output int stall);
    stall = 0;
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    while (!cfg_ready && stall < 200) begin
      @(posedge clk); #1;
      stall++;
    end
    checkOutput("cfg_accept_in_time", stall < 200, 1);
    @(posedge clk); #1;
    cfg_we = 1'b0; cfg_addr = 3'd0;
    case (a)
      3'd0: mShCx = int'(d[10:0]);
      3'd1: mShCy = int'(d[10:0]);
      3'd2: mShEn = int'(d[0]);
      3'd3: mPtr  = int'(d[LB-1:0]);
      3'd4: begin
        expLut.push_back(mPtr * 256 + int'(d[7:0]));
        mPtr = (mPtr + 1) % (1 << LB);
      end
      3'd5: mErr = mErr & ~d[2:0];
      default: ;
    endcase
  endtask

  task automatic checkReadyLut(input string tag);
    cfg_addr = 3'd4;
    #1;
    checkOutput(tag, cfg_ready, (mState == 1) ? 0 : 1);
    cfg_addr = 3'd0;
  endtask

  // Scoreboard side: compare every accepted beat and every table write strobe.
  always @(negedge clk) begin : monitor
    int e;
    if (aresetn && s_tvalid && s_tready) begin
      checkOutput("pix_sb_pending", expPix.size() != 0, 1);
      if (expPix.size() != 0) begin
        e = expPix.pop_front();
        checkOutput("pix_x", pix_x, e / 4096);
        checkOutput("pix_y", pix_y, e % 4096);
      end
    end
    if (lut_we === 1'b1) begin
      checkOutput("lut_sb_pending", expLut.size() != 0, 1);
      if (expLut.size() != 0) begin
        e = expLut.pop_front();
        checkOutput("lut_addr", lut_addr, e / 256);
        checkOutput("lut_data", lut_data, e % 256);
      end
    end
  end

  initial begin : main
    int st;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkState("reset");
    checkOutput("reset.pix_x", pix_x, 0);
    checkOutput("reset.pix_y", pix_y, 0);
    checkOutput("reset.lut_we", lut_we, 0);
    checkOutput("reset.cfg_ready", cfg_ready, 1);
    aresetn = 1'b1;
    @(posedge clk); #1;

    // Shadow writes only take effect on the SOF beat.
    cfgWrite(3'd0, 16'd100, st);
    cfgWrite(3'd1, 16'd50, st);
    cfgWrite(3'd2, 16'd1, st);
    checkState("pre_sof");
    applyStimulus(1'b1, 1'b0);
    checkState("post_sof");
    applyStimulus(1'b0, 1'b0); applyStimulus(1'b0, 1'b0); applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < H; i++) applyStimulus(1'b0, i == H - 1);

    // Table writes issued mid-frame stall until the frame's last beat.
    cfgWrite(3'd3, 16'd1022, st);
    checkReadyLut("cfg_ready_active");
    fork
      begin
        for (int i = 0; i < H; i++) applyStimulus(1'b0, i == H - 1);
      end
      begin
        int stl;
        cfgWrite(3'd4, 16'h00AA, stl);
        checkOutput("lut_stall_cycles", stl, H);
        cfgWrite(3'd4, 16'h00BB, stl);
        cfgWrite(3'd4, 16'h00CC, stl);
      end
    join
    repeat (2) @(posedge clk);
    #1;
    checkOutput("lut_all_seen", expLut.size(), 0);
    checkState("frame1_end");
    checkReadyLut("cfg_ready_blank");
    applyStimulus(1'b0, 1'b0);

    // Frame 2: backpressure, early end of line, clear, restart mid-frame.
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    s_tvalid = 1'b1; s_tready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("stall.pix_x", pix_x, mX);
    checkOutput("stall.pix_y", pix_y, mY);
    checkOutput("stall.err", err_flags, mErr);
    s_tvalid = 1'b0;
    applyStimulus(1'b0, 1'b1);
    checkOutput("early_eol.err", err_flags, 3'b001);
    checkState("early_eol");
    cfgWrite(3'd5, 16'd1, st);
    checkState("err_clear");
    applyStimulus(1'b0, 1'b0); applyStimulus(1'b0, 1'b0);
    cfgWrite(3'd0, 16'd200, st);
    applyStimulus(1'b1, 1'b0);
    checkState("restart");

    applyStimulus(1'b0, 1'b0); applyStimulus(1'b0, 1'b0); applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("late_eol.err", err_flags, 3'b110);
    cfgWrite(3'd5, 16'd7, st);
    checkState("err_clear_all");

    // A clear coinciding with an error event keeps the flag set.
    applyStimulus(1'b0, 1'b0); applyStimulus(1'b0, 1'b0); applyStimulus(1'b0, 1'b0);
    fork
      applyStimulus(1'b0, 1'b0);
      cfgWrite(3'd5, 16'd2, st);
    join
    mErr = 3'b010;
    checkOutput("err_event_wins", err_flags, 3'b010);
    applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < H; i++) applyStimulus(1'b0, i == H - 1);

    // Frame 4 interrupted by reset at (2,1).
    applyStimulus(1'b1, 1'b0);
    for (int i = 1; i < H; i++) applyStimulus(1'b0, i == H - 1);
    applyStimulus(1'b0, 1'b0); applyStimulus(1'b0, 1'b0);
    checkOutput("pre_reset.pix_x", pix_x, 2);
    aresetn = 1'b0;
    #2;
    modelReset();
    checkState("async_reset");
    checkOutput("async_reset.pix_x", pix_x, 0);
    checkOutput("async_reset.pix_y", pix_y, 0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("in_reset.lut_we", lut_we, 0);
    aresetn = 1'b1;
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0);
    checkOutput("post_reset.pix_x", pix_x, 0);
    checkOutput("post_reset.pix_y", pix_y, 0);
    checkState("post_reset");
    checkReadyLut("cfg_ready_wait_sof");
    applyStimulus(1'b1, 1'b0);
    checkState("sof_after_reset");
    repeat (2) @(posedge clk);
    #1;
    checkOutput("pix_sb_drained", expPix.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/vignette_ctrl.md
Name: vignette_ctrl

Overview:
Controller and sequencer for the vignette filter stage.
- Monitors the AXI4-Stream video handshake at the filter input and generates per-beat pixel coordinates.
- Holds the vignette configuration in shadow registers and applies it atomically at start of frame.
- Gates loading of the 1024x8 vignette gain table so that table writes happen only outside active video.
- Reports framing errors and a frame counter.

Parameters:
H_ACTIVE, 1920, active pixels per line
V_ACTIVE, 1080, active lines per frame
LUT_BITS, 10, vignette table address width (depth 2^LUT_BITS)
MUL_BITS, 8, vignette table data width

Ports:
clk  in  1  clock
aresetn  in  1  reset
s_tvalid  in  1  monitored stream valid
s_tready  in  1  monitored stream ready; beat = s_tvalid & s_tready
s_tuser  in  1  start of frame
s_tlast  in  1  end of line
pix_x  out  11  x coordinate of the beat currently on the bus
pix_y  out  11  y coordinate of the beat currently on the bus
cfg_we  in  1  register write strobe
cfg_addr  in  3  register address
cfg_wdata  in  16  register write data
cfg_ready  out  1  write accepted when cfg_we & cfg_ready
center_x  out  11  active vignette centre x
center_y  out  11  active vignette centre y
vig_enable  out  1  active enable; the filter is bypassed when 0
lut_we  out  1  gain table write strobe
lut_addr  out  LUT_BITS  gain table write address
lut_data  out  MUL_BITS  gain table write data
frame_cnt  out  16  frames started; wraps
err_flags  out  3  sticky: [0] early_eol, [1] late_eol, [2] sof_mid_frame

Behaviour:
- Reset is asynchronous, active-low (aresetn); clock is clk. All registers clear on reset, except the following reset values:
  - centers = 960/540
  - vig_enable = 0
  - LUT pointer = 0
  - state = WAIT_SOF
- Reset mid-frame discards the frame. No outputs pulse during reset.

Register map (writes only):
- 0: shadow centre x = wdata[10:0]
- 1: shadow centre y = wdata[10:0]
- 2: shadow enable = wdata[0]
- 3: LUT pointer = wdata[LUT_BITS-1:0]
- 4: LUT write
  - lut_we = 1 for exactly one cycle, registered: the cycle after acceptance.
  - lut_addr = pointer, lut_data = wdata[MUL_BITS-1:0].
  - Pointer then increments, wrapping 2^LUT_BITS-1 -> 0.
- 5: err_flags &= ~wdata[2:0] (write-1-to-clear). An error event in the same cycle wins: the flag stays set.
- 6, 7: accepted and ignored.

cfg_ready:
- 0 only when cfg_addr = 4 and state = ACTIVE.
- 1 for all other addresses, always. A write to address 4 stalls until blanking.

Shadow apply:
- Shadow centres and enable are copied to center_x, center_y and vig_enable on the clock edge of an accepted SOF beat (tuser = 1), in any state. They are never applied mid-frame.
- A shadow write in the same cycle as the SOF beat is included in that apply.
- frame_cnt increments on the same edge.

Coordinates:
- Internal counters xc, yc.
- pix_x = s_tuser ? 0 : xc and pix_y = s_tuser ? 0 : yc (combinational; 0 latency).
- On an accepted beat with current coordinate (x, y):
  - If tlast: xc = 0, yc = y + 1, saturating at 2047.
  - Otherwise: xc = x + 1, saturating at 2047.

State machine (WAIT_SOF, ACTIVE, BLANK):
- WAIT_SOF: beats without tuser are ignored and the counters hold. An accepted tuser beat -> ACTIVE.
- ACTIVE: an accepted tlast beat with y = V_ACTIVE-1 -> BLANK.
- ACTIVE: an accepted tuser beat with a coordinate other than the start-of-frame beat sets err[2] and restarts the frame at (0,0). State stays ACTIVE.
- BLANK: an accepted tuser beat -> ACTIVE. Beats without tuser hold the counters.

Errors (ACTIVE only):
- err[0]: tlast on a beat with x < H_ACTIVE-1.
- err[1]: a beat with x = H_ACTIVE-1 and no tlast; counting continues.

Test Plan:
- Reset, then write addr0 = 100, addr1 = 50, addr2 = 1, then send a 4x3 frame (H_ACTIVE = 4, V_ACTIVE = 3) -> center_x/center_y/vig_enable stay 960/540/0 until the SOF beat edge, then 100/50/1. pix_x/pix_y sequence is (0,0)..(3,0),(0,1)..(3,2). frame_cnt = 1; state reaches BLANK.
- During ACTIVE, write addr3 = 1022, then three writes to addr4 with data AA, BB, CC -> cfg_ready = 0 until BLANK. Then lut_we pulses with addr 1022, 1023, 0 and data AA, BB, CC.
- Drop s_tready for 5 cycles mid-line with s_tvalid high -> pix_x/pix_y hold; no counter advance; no error.
- tlast at x = 2 with H_ACTIVE = 4 -> err_flags = 3'b001, next line starts at x = 0. Write addr5 = 1 -> err_flags = 0.
- tuser at (2,1) -> err_flags[2] = 1, pix = (0,0), frame_cnt increments, shadow config applied.
- Assert aresetn low mid-line at (2,1), release, then send a non-tuser beat -> coordinates stay (0,0), state WAIT_SOF, all outputs at reset values.
